// File: rtl/dispatch_busytable_if.sv
// Rename-to-dispatch and dispatch-to-issue-queue handshake bundle.
// The master side is the upstream/downstream environment; the slave side is the dispatch stage.
interface dispatch_busytable_if #(
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 160
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PREG_W-1:0]    in_prs1;
    logic [PREG_W-1:0]    in_prs2;
    logic                 in_src1_is_reg;
    logic                 in_src2_is_reg;
    logic [PREG_W-1:0]    in_prd;
    logic                 in_need_to_wb;
    logic [PAYLOAD_W-1:0] in_payload;

    logic                 out_valid;
    logic                 out_ready;
    logic [PREG_W-1:0]    out_prs1;
    logic [PREG_W-1:0]    out_prs2;
    logic [PREG_W-1:0]    out_prd;
    logic                 out_src1_is_reg;
    logic                 out_src2_is_reg;
    logic                 out_need_to_wb;
    logic                 out_src1_state;
    logic                 out_src2_state;
    logic [PAYLOAD_W-1:0] out_payload;

    modport master (
        output in_valid, in_prs1, in_prs2, in_src1_is_reg, in_src2_is_reg,
               in_prd, in_need_to_wb, in_payload, out_ready,
        input  in_ready, out_valid, out_prs1, out_prs2, out_prd,
               out_src1_is_reg, out_src2_is_reg, out_need_to_wb,
               out_src1_state, out_src2_state, out_payload
    );

    modport slave (
        input  in_valid, in_prs1, in_prs2, in_src1_is_reg, in_src2_is_reg,
               in_prd, in_need_to_wb, in_payload, out_ready,
        output in_ready, out_valid, out_prs1, out_prs2, out_prd,
               out_src1_is_reg, out_src2_is_reg, out_need_to_wb,
               out_src1_state, out_src2_state, out_payload
    );
endinterface

// File: rtl/dispatch_busytable.sv
// Dispatch stage: per-physical-register busy table feeding operand state bits,
// followed by a single registered output stage toward the issue queue.
module dispatch_busytable #(
    parameter int PREG_NUM  = 64,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 160
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_prd,
    dispatch_busytable_if.slave io
);
    logic [PREG_NUM-1:0]  busy_q, busy_d;

    logic                 outValid_q, outValid_d;
    logic [PREG_W-1:0]    outPrs1_q, outPrs1_d;
    logic [PREG_W-1:0]    outPrs2_q, outPrs2_d;
    logic [PREG_W-1:0]    outPrd_q, outPrd_d;
    logic                 outSrc1IsReg_q, outSrc1IsReg_d;
    logic                 outSrc2IsReg_q, outSrc2IsReg_d;
    logic                 outNeedToWb_q, outNeedToWb_d;
    logic                 outSrc1State_q, outSrc1State_d;
    logic                 outSrc2State_q, outSrc2State_d;
    logic [PAYLOAD_W-1:0] outPayload_q, outPayload_d;

    logic inReady;
    logic accept;
    logic fire;
    logic wbHit;
    logic allocate;
    logic src1Busy;
    logic src2Busy;

    assign inReady  = ~flush & (~outValid_q | io.out_ready);
    assign accept   = io.in_valid & inReady;
    assign fire     = outValid_q & io.out_ready;
    assign wbHit    = wb_valid & (wb_prd != '0);
    assign allocate = accept & io.in_need_to_wb & (io.in_prd != '0);

    // Lookups use the table before this cycle's allocation; a same-cycle wakeup bypasses it.
    assign src1Busy = io.in_src1_is_reg & (io.in_prs1 != '0) & busy_q[io.in_prs1]
                      & ~(wbHit & (wb_prd == io.in_prs1));
    assign src2Busy = io.in_src2_is_reg & (io.in_prs2 != '0) & busy_q[io.in_prs2]
                      & ~(wbHit & (wb_prd == io.in_prs2));

    always_comb begin
        busy_d = busy_q;
        if (wbHit) begin
            busy_d[wb_prd] = 1'b0;
        end
        if (allocate) begin
            busy_d[io.in_prd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        outValid_d     = outValid_q;
        outPrs1_d      = outPrs1_q;
        outPrs2_d      = outPrs2_q;
        outPrd_d       = outPrd_q;
        outSrc1IsReg_d = outSrc1IsReg_q;
        outSrc2IsReg_d = outSrc2IsReg_q;
        outNeedToWb_d  = outNeedToWb_q;
        outSrc1State_d = outSrc1State_q;
        outSrc2State_d = outSrc2State_q;
        outPayload_d   = outPayload_q;

        // A held entry keeps listening to wakeups so the issue queue sees fresh state bits.
        if (wbHit && outSrc1IsReg_q && (outPrs1_q == wb_prd)) begin
            outSrc1State_d = 1'b0;
        end
        if (wbHit && outSrc2IsReg_q && (outPrs2_q == wb_prd)) begin
            outSrc2State_d = 1'b0;
        end

        if (accept) begin
            outValid_d     = 1'b1;
            outPrs1_d      = io.in_prs1;
            outPrs2_d      = io.in_prs2;
            outPrd_d       = io.in_prd;
            outSrc1IsReg_d = io.in_src1_is_reg;
            outSrc2IsReg_d = io.in_src2_is_reg;
            outNeedToWb_d  = io.in_need_to_wb;
            outSrc1State_d = src1Busy;
            outSrc2State_d = src2Busy;
            outPayload_d   = io.in_payload;
        end else if (fire) begin
            outValid_d = 1'b0;
        end

        if (flush) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outValid_q     <= 1'b0;
            outPrs1_q      <= '0;
            outPrs2_q      <= '0;
            outPrd_q       <= '0;
            outSrc1IsReg_q <= 1'b0;
            outSrc2IsReg_q <= 1'b0;
            outNeedToWb_q  <= 1'b0;
            outSrc1State_q <= 1'b0;
            outSrc2State_q <= 1'b0;
            outPayload_q   <= '0;
        end else begin
            outValid_q     <= outValid_d;
            outPrs1_q      <= outPrs1_d;
            outPrs2_q      <= outPrs2_d;
            outPrd_q       <= outPrd_d;
            outSrc1IsReg_q <= outSrc1IsReg_d;
            outSrc2IsReg_q <= outSrc2IsReg_d;
            outNeedToWb_q  <= outNeedToWb_d;
            outSrc1State_q <= outSrc1State_d;
            outSrc2State_q <= outSrc2State_d;
            outPayload_q   <= outPayload_d;
        end
    end

    assign io.in_ready        = inReady;
    assign io.out_valid       = outValid_q;
    assign io.out_prs1        = outPrs1_q;
    assign io.out_prs2        = outPrs2_q;
    assign io.out_prd         = outPrd_q;
    assign io.out_src1_is_reg = outSrc1IsReg_q;
    assign io.out_src2_is_reg = outSrc2IsReg_q;
    assign io.out_need_to_wb  = outNeedToWb_q;
    assign io.out_src1_state  = outSrc1State_q;
    assign io.out_src2_state  = outSrc2State_q;
    assign io.out_payload     = outPayload_q;
endmodule

// File: tb/tb_dispatch_busytable.sv
// Scoreboard bench for dispatch_busytable: a behavioural model pushes expected
// issue-queue entries, and a negedge monitor compares whatever the DUT presents.
module tb_dispatch_busytable;
    localparam int PREG_W    = 6;
    localparam int PAYLOAD_W = 160;

    typedef struct packed {
        logic [PREG_W-1:0]    prs1;
        logic [PREG_W-1:0]    prs2;
        logic [PREG_W-1:0]    prd;
        logic                 r1;
        logic                 r2;
        logic                 nw;
        logic                 s1;
        logic                 s2;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic              wbValid;
    logic [PREG_W-1:0] wbPrd;

    dispatch_busytable_if #(.PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) io ();

    dispatch_busytable #(
        .PREG_NUM (64),
        .PREG_W   (PREG_W),
        .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush),
        .wb_valid(wbValid),
        .wb_prd  (wbPrd),
        .io      (io)
    );

    always #5 clock = ~clock;

    entry_t sbQ[$];
    bit     mBusy[64];
    bit     mValid;
    bit     monitorOn;
    int     vectors;
    int     miscompares;

    function automatic bit operandBusy(input bit isReg, input logic [PREG_W-1:0] prs);
        return isReg && (prs != 0) && mBusy[prs] && !(wbValid && (wbPrd == prs));
    endfunction

    // Reference model: the spec's rules applied once per rising edge to plain arrays.
    always @(posedge clock) begin
        bit     acc;
        bit     fired;
        entry_t e;
        if (reset || flush) begin
            foreach (mBusy[k]) mBusy[k] = 1'b0;
            mValid = 1'b0;
            sbQ.delete();
        end else begin
            acc   = io.in_valid && (!mValid || io.out_ready);
            fired = mValid && io.out_ready;
            if (mValid && !fired && sbQ.size() > 0 && wbValid && wbPrd != 0) begin
                e = sbQ[0];
                if (e.r1 && e.prs1 == wbPrd) e.s1 = 1'b0;
                if (e.r2 && e.prs2 == wbPrd) e.s2 = 1'b0;
                sbQ[0] = e;
            end
            if (acc) begin
                e.prs1    = io.in_prs1;
                e.prs2    = io.in_prs2;
                e.prd     = io.in_prd;
                e.r1      = io.in_src1_is_reg;
                e.r2      = io.in_src2_is_reg;
                e.nw      = io.in_need_to_wb;
                e.s1      = operandBusy(io.in_src1_is_reg, io.in_prs1);
                e.s2      = operandBusy(io.in_src2_is_reg, io.in_prs2);
                e.payload = io.in_payload;
                sbQ.push_back(e);
            end
            if (wbValid && wbPrd != 0) mBusy[wbPrd] = 1'b0;
            if (acc && io.in_need_to_wb && io.in_prd != 0) mBusy[io.in_prd] = 1'b1;
            if (acc) mValid = 1'b1;
            else if (fired) mValid = 1'b0;
        end
    end

    task automatic checkOutput();
        entry_t got;
        bit     expReady;
        expReady = !flush && (!mValid || io.out_ready);
        vectors++;
        if (io.in_ready !== expReady) begin
            miscompares++;
            $display("[TB] FAIL in_ready at %0t: got %b, expected %b", $time, io.in_ready, expReady);
        end
        vectors++;
        if (io.out_valid !== mValid) begin
            miscompares++;
            $display("[TB] FAIL out_valid at %0t: got %b, expected %b", $time, io.out_valid, mValid);
        end
        if (io.out_valid === 1'b1) begin
            got = {io.out_prs1, io.out_prs2, io.out_prd, io.out_src1_is_reg, io.out_src2_is_reg,
                   io.out_need_to_wb, io.out_src1_state, io.out_src2_state, io.out_payload};
            vectors++;
            if (sbQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL entry at %0t: got %h, expected no entry", $time, got);
            end else begin
                if (got !== sbQ[0]) begin
                    miscompares++;
                    $display("[TB] FAIL entry at %0t: got %h, expected %h", $time, got, sbQ[0]);
                end
                if (io.out_ready && !flush && !reset) void'(sbQ.pop_front());
            end
        end
    endtask

    always @(negedge clock) begin
        if (monitorOn) checkOutput();
    end

    task automatic checkResetState();
        logic [PAYLOAD_W+23:0] got;
        got = {io.out_valid, io.out_prs1, io.out_prs2, io.out_prd, io.out_src1_is_reg,
               io.out_src2_is_reg, io.out_need_to_wb, io.out_src1_state, io.out_src2_state,
               io.out_payload};
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got %h, expected all zero", got);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [PREG_W-1:0] p1, input bit r1,
                                 input logic [PREG_W-1:0] p2, input bit r2,
                                 input logic [PREG_W-1:0] pd, input bit nw, input bit ordy,
                                 input bit wbv, input logic [PREG_W-1:0] wbp,
                                 input bit fl, input bit rst);
        io.in_valid       = v;
        io.in_prs1        = p1;
        io.in_src1_is_reg = r1;
        io.in_prs2        = p2;
        io.in_src2_is_reg = r2;
        io.in_prd         = pd;
        io.in_need_to_wb  = nw;
        io.in_payload     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        io.out_ready      = ordy;
        wbValid           = wbv;
        wbPrd             = wbp;
        flush             = fl;
        reset             = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input bit ordy);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, ordy, 0, 0, 0, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        monitorOn   = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkResetState();
        monitorOn = 1'b1;

        // Producer of p9, then a dependent consumer that stalls and is woken while held.
        applyStimulus(1, 5, 1, 7, 1, 9, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 9, 1, 7, 1, 10, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        applyStimulus(1, 2, 1, 3, 1, 11, 1, 0, 0, 0, 0, 0);
        idle(1);
        idle(1);

        // Same-cycle wakeup bypass versus plain busy lookup on p12.
        applyStimulus(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 12, 1, 12, 1, 0, 0, 1, 1, 12, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 12, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 12, 0, 0);

        // p0 is never busy; a non-register source ignores a busy p3.
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 3, 1, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0);

        // Continuous traffic with out_ready toggling.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 6'(i + 1), 1, 6'(i + 2), 1, 6'(i + 30), 1, (i % 2) == 0, 0, 0, 0, 0);
        end
        idle(1);

        // Flush with a held entry and busy p4/p20, then consumers see a clean table.
        applyStimulus(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 4, 1, 20, 1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 4, 1, 20, 1, 0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // Reset while stalled drops the entry and clears the table.
        applyStimulus(1, 1, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkResetState();
        applyStimulus(1, 5, 1, 5, 1, 0, 0, 1, 0, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 9) < 7,
                          6'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                          6'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                          6'($urandom_range(0, 15)), $urandom_range(0, 4) != 0,
                          $urandom_range(0, 9) < 6,
                          $urandom_range(0, 9) < 4, 6'($urandom_range(0, 15)),
                          $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
        end
        idle(1);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dispatch_busytable.md
Name: dispatch_busytable

Overview:
- Dispatch stage sitting between rename and the issue queue; it is the transmitting end of the issue-queue enqueue handshake.
- Holds a per-physical-register busy table, set on destination allocation and cleared by writeback wakeup.
- Attaches src1/src2 state bits to each instruction. State 1 = operand not ready; the issue queue issues only when both are 0.
- Registers the instruction into a single-entry output stage with valid/ready backpressure, and keeps that stage's state bits updated by wakeup while it stalls.

Parameters:
- PREG_NUM, 64, number of physical registers (busy table depth).
- PREG_W, 6, physical register index width (log2 PREG_NUM).
- PAYLOAD_W, 160, opaque bundle (pc, imm, type fields, robidx/flag, ls_size, old_prd) passed through unchanged.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  full pipeline flush
- in_valid  in  1  instruction from rename valid
- in_ready  out  1  dispatch can accept
- in_prs1 / in_prs2  in  PREG_W each  source physical registers
- in_src1_is_reg / in_src2_is_reg  in  1 each  source reads a register
- in_prd  in  PREG_W  destination physical register
- in_need_to_wb  in  1  instruction writes prd
- in_payload  in  PAYLOAD_W  pass-through bundle
- out_valid  out  1  enqueue request to issue queue
- out_ready  in  1  issue queue enqueue ready
- out_prs1 / out_prs2 / out_prd  out  PREG_W each  registered copies
- out_src1_is_reg / out_src2_is_reg / out_need_to_wb  out  1 each  registered copies
- out_src1_state / out_src2_state  out  1 each  1 = operand busy
- out_payload  out  PAYLOAD_W  registered copy
- wb_valid  in  1  writeback wakeup
- wb_prd  in  PREG_W  register being written back

Behaviour:
Reset:
- Clock and reset exactly as decided: one clock named clock; synchronous, active-high reset named reset.
- reset=1 at a rising edge: busy table all 0, out_valid=0, all out_* data 0.
- Reset mid-stall drops the held entry.

Handshake:
- in_ready = ~flush & (~out_valid | out_ready).
- Accept = in_valid & in_ready. On accept the output stage loads next edge (latency 1).
- out_valid/out_* stay stable while out_valid & ~out_ready. The only exceptions are the state bits, which may fall 1->0 via wakeup.
- Fire = out_valid & out_ready with no accept: out_valid -> 0.
- Fire and accept in the same cycle: back-to-back, out_valid stays 1.

Source state on accept:
- srcN_state = srcN_is_reg & (prsN != 0) & busy[prsN] & ~(wb_valid & wb_prd == prsN).
- The wb term is a same-cycle bypass.
- Reads see the busy table before this cycle's own allocation.

Wakeup:
- wb_valid & wb_prd == p: busy[p] <= 0.
- Also, while held, out_srcN_state <= 0 whenever out_srcN_is_reg and out_prsN == wb_prd.
- wb_prd == 0 is ignored.

Allocation:
- On accept with in_need_to_wb & in_prd != 0: busy[in_prd] <= 1.
- If the same cycle also has wb_prd == in_prd, set wins.
- busy[0] is hard 0.

Back-to-back dependence:
- Consumer accepted the cycle after its producer sees busy=1 (table registered, visible next cycle).

Flush:
- Clears out_valid and the entire busy table at the next edge; in_ready=0 during flush.
- Flush is asserted only after all older in-flight instructions have written back.
- Flush has priority over accept, allocation and wakeup in that cycle.

Simultaneous events:
- Reset > flush > (allocation, wakeup, handshake).

Test Plan:
1. After reset, accept prs1=5, prs2=7, is_reg=1/1, prd=9, out_ready=1 -> next cycle out_valid=1, states 0/0; following cycle busy[9]=1.
2. Accept prd=9, then next cycle accept prs1=9 -> out_src1_state=1. Then wb_valid, wb_prd=9 while out_ready=0 -> out_src1_state falls to 0 next cycle, out_valid held, in_ready=0.
3. Accept prs1=12 with busy[12]=1 and wb_valid, wb_prd=12 in the same cycle -> out_src1_state=0.
4. Continuous in_valid, out_ready toggling 1,0,1 -> no instruction lost or duplicated; in_ready tracks ~out_valid | out_ready.
5. prd=0 with need_to_wb=1, or src_is_reg=0 with prs=3 busy -> busy[0] stays 0 and state=0.
6. Flush with out_valid=1 and busy[4]=busy[20]=1 -> next cycle out_valid=0, busy table all 0, in_ready=0 during flush.
